// File: rtl/exe_stage.sv
// exe_stage: execute stage and EX/MEM pipeline register of the five-stage MIPS pipeline.
//
// Ports
//   clk, rst_n        pipeline clock (state moves on the falling edge), async active-low reset
//   flush, hold       bubble / freeze the EX/MEM register on the next edge (flush wins)
//   EXE_*             ID/EX register outputs: control, register indices, operands, imm16, AluCtr
//   WB_RegWr/Rw/busW  write-back result, used as the second-priority forwarding source
//   MEM_*             registered EX/MEM outputs toward data memory
//
// Operands are forwarded from the instruction one ahead (the current MEM_* register) first,
// then from WB. Loads sitting in MEM are not forwarded; the hazard unit stalls those.
module exe_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        hold,
    input  logic        EXE_MemWr,
    input  logic        EXE_MemtoReg,
    input  logic        EXE_RegWr,
    input  logic        EXE_ExtOP,
    input  logic        EXE_AluSrc,
    input  logic        EXE_MemRead,
    input  logic [4:0]  EXE_Rw,
    input  logic [4:0]  EXE_Rs,
    input  logic [4:0]  EXE_Rt,
    input  logic [31:0] EXE_busA,
    input  logic [31:0] EXE_busB,
    input  logic [15:0] EXE_imm16,
    input  logic [2:0]  EXE_AluCtr,
    input  logic        WB_RegWr,
    input  logic [4:0]  WB_Rw,
    input  logic [31:0] WB_busW,
    output logic        MEM_MemWr,
    output logic        MEM_MemtoReg,
    output logic        MEM_RegWr,
    output logic        MEM_MemRead,
    output logic [4:0]  MEM_Rw,
    output logic [31:0] MEM_ALUout,
    output logic [31:0] MEM_busB,
    output logic        MEM_Zero,
    output logic        MEM_Overflow
);

    logic        mem_fwd_ok;
    logic [31:0] fwd_a, fwd_b, ext, op_a, op_b;
    logic [31:0] sum, diff, alu_res;
    logic        ovf;

    // MEM can only supply a value if it writes a register from the ALU (not a load).
    assign mem_fwd_ok = MEM_RegWr && !MEM_MemtoReg && (MEM_Rw != 5'd0);

    always_comb begin
        fwd_a = EXE_busA;
        if (mem_fwd_ok && (MEM_Rw == EXE_Rs))
            fwd_a = MEM_ALUout;
        else if (WB_RegWr && (WB_Rw != 5'd0) && (WB_Rw == EXE_Rs))
            fwd_a = WB_busW;
    end

    always_comb begin
        fwd_b = EXE_busB;
        if (mem_fwd_ok && (MEM_Rw == EXE_Rt))
            fwd_b = MEM_ALUout;
        else if (WB_RegWr && (WB_Rw != 5'd0) && (WB_Rw == EXE_Rt))
            fwd_b = WB_busW;
    end

    assign ext  = EXE_ExtOP ? {{16{EXE_imm16[15]}}, EXE_imm16} : {16'd0, EXE_imm16};
    assign op_a = fwd_a;
    assign op_b = EXE_AluSrc ? ext : fwd_b;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // Signed overflow only matters for the checked add: same-sign operands, sum flips sign.
    assign ovf = (EXE_AluCtr == 3'b110) && (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);

    always_comb begin
        alu_res = sum;
        case (EXE_AluCtr)
            3'b000: alu_res = sum;
            3'b001: alu_res = diff;
            3'b010: alu_res = op_a & op_b;
            3'b011: alu_res = op_a | op_b;
            3'b100: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            3'b101: alu_res = {31'd0, op_a < op_b};
            3'b110: alu_res = sum;
            3'b111: alu_res = {op_b[15:0], 16'd0};
            default: alu_res = sum;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            MEM_MemWr    <= 1'b0;
            MEM_MemtoReg <= 1'b0;
            MEM_RegWr    <= 1'b0;
            MEM_MemRead  <= 1'b0;
            MEM_Rw       <= 5'd0;
            MEM_ALUout   <= 32'd0;
            MEM_busB     <= 32'd0;
            MEM_Zero     <= 1'b0;
            MEM_Overflow <= 1'b0;
        end else if (!hold) begin
            // An overflowing add keeps its result but must not commit anywhere.
            MEM_MemWr    <= EXE_MemWr && !ovf;
            MEM_MemtoReg <= EXE_MemtoReg;
            MEM_RegWr    <= EXE_RegWr && !ovf;
            MEM_MemRead  <= EXE_MemRead;
            MEM_Rw       <= EXE_Rw;
            MEM_ALUout   <= alu_res;
            MEM_busB     <= fwd_b;
            MEM_Zero     <= (alu_res == 32'd0);
            MEM_Overflow <= ovf;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: driver pushes hand-computed expectations into a queue,
// a monitor on the rising edge (opposite the active falling edge) pops and compares.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, hold = 1'b0;
    logic        EXE_MemWr = 0, EXE_MemtoReg = 0, EXE_RegWr = 0, EXE_ExtOP = 0, EXE_AluSrc = 0, EXE_MemRead = 0;
    logic [4:0]  EXE_Rw = 0, EXE_Rs = 0, EXE_Rt = 0;
    logic [31:0] EXE_busA = 0, EXE_busB = 0;
    logic [15:0] EXE_imm16 = 0;
    logic [2:0]  EXE_AluCtr = 0;
    logic        WB_RegWr = 0;
    logic [4:0]  WB_Rw = 0;
    logic [31:0] WB_busW = 0;
    logic        MEM_MemWr, MEM_MemtoReg, MEM_RegWr, MEM_MemRead;
    logic [4:0]  MEM_Rw;
    logic [31:0] MEM_ALUout, MEM_busB;
    logic        MEM_Zero, MEM_Overflow;

    typedef struct packed {
        logic        memwr, memtoreg, regwr, memread;
        logic [4:0]  rw;
        logic [31:0] alu, busb;
        logic        zero, ovf;
    } out_t;

    out_t  got, mon_e;
    string mon_n;
    out_t  exp_q[$];
    string nm_q[$];
    int    checks = 0, failures = 0;

    localparam out_t ZEROS = '0;

    exe_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .EXE_MemWr(EXE_MemWr), .EXE_MemtoReg(EXE_MemtoReg), .EXE_RegWr(EXE_RegWr),
        .EXE_ExtOP(EXE_ExtOP), .EXE_AluSrc(EXE_AluSrc), .EXE_MemRead(EXE_MemRead),
        .EXE_Rw(EXE_Rw), .EXE_Rs(EXE_Rs), .EXE_Rt(EXE_Rt),
        .EXE_busA(EXE_busA), .EXE_busB(EXE_busB), .EXE_imm16(EXE_imm16), .EXE_AluCtr(EXE_AluCtr),
        .WB_RegWr(WB_RegWr), .WB_Rw(WB_Rw), .WB_busW(WB_busW),
        .MEM_MemWr(MEM_MemWr), .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWr(MEM_RegWr),
        .MEM_MemRead(MEM_MemRead), .MEM_Rw(MEM_Rw), .MEM_ALUout(MEM_ALUout),
        .MEM_busB(MEM_busB), .MEM_Zero(MEM_Zero), .MEM_Overflow(MEM_Overflow)
    );

    always #5 clk = ~clk;

    assign got = '{MEM_MemWr, MEM_MemtoReg, MEM_RegWr, MEM_MemRead, MEM_Rw,
                   MEM_ALUout, MEM_busB, MEM_Zero, MEM_Overflow};

    task automatic chk(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got alu=%h busb=%h rw=%0d wr/m2r/rw/rd=%b%b%b%b z=%b ovf=%b, want alu=%h busb=%h rw=%0d wr/m2r/rw/rd=%b%b%b%b z=%b ovf=%b",
                     nm, a.alu, a.busb, a.rw, a.memwr, a.memtoreg, a.regwr, a.memread, a.zero, a.ovf,
                     e.alu, e.busb, e.rw, e.memwr, e.memtoreg, e.regwr, e.memread, e.zero, e.ovf);
        end
    endtask

    // Monitor: one expectation per falling edge, checked at the following rising edge.
    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = nm_q.pop_front();
            chk(mon_n, got, mon_e);
        end
    end

    function automatic out_t ex(input logic [31:0] alu, busb, input logic [4:0] rw,
                                input logic regwr, memwr, memtoreg, memread, ovf);
        ex = '{memwr, memtoreg, regwr, memread, rw, alu, busb, (alu == 32'd0), ovf};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string nm, input out_t e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic set_in(input logic [2:0] alu, input logic [31:0] a, b, input logic [15:0] imm,
                          input logic extop, alusrc, input logic [4:0] rs, rt, rw,
                          input logic regwr, memwr, memtoreg, memread);
        EXE_AluCtr = alu; EXE_busA = a; EXE_busB = b; EXE_imm16 = imm;
        EXE_ExtOP = extop; EXE_AluSrc = alusrc; EXE_Rs = rs; EXE_Rt = rt; EXE_Rw = rw;
        EXE_RegWr = regwr; EXE_MemWr = memwr; EXE_MemtoReg = memtoreg; EXE_MemRead = memread;
    endtask

    task automatic set_wb(input logic wr, input logic [4:0] rw, input logic [31:0] d);
        WB_RegWr = wr; WB_Rw = rw; WB_busW = d;
    endtask

    initial begin
        #3;
        chk("reset_initial", got, ZEROS);
        nxt();
        rst_n = 1'b1;

        // ALU sweep, A=-1 B=1
        set_in(3'd0, 32'hFFFF_FFFF, 32'd1, 16'h0, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0);
        vec("addu", ex(32'h0, 32'd1, 3, 1, 0, 0, 0, 0));
        nxt(); EXE_AluCtr = 3'd1; vec("subu", ex(32'hFFFF_FFFE, 32'd1, 3, 1, 0, 0, 0, 0));
        nxt(); EXE_AluCtr = 3'd2; vec("and",  ex(32'h1, 32'd1, 3, 1, 0, 0, 0, 0));
        nxt(); EXE_AluCtr = 3'd3; vec("or",   ex(32'hFFFF_FFFF, 32'd1, 3, 1, 0, 0, 0, 0));
        nxt(); EXE_AluCtr = 3'd4; vec("slt",  ex(32'h1, 32'd1, 3, 1, 0, 0, 0, 0));
        nxt(); EXE_AluCtr = 3'd5; vec("sltu", ex(32'h0, 32'd1, 3, 1, 0, 0, 0, 0));
        nxt(); EXE_AluCtr = 3'd6; vec("add_noovf", ex(32'h0, 32'd1, 3, 1, 0, 0, 0, 0));
        nxt(); set_in(3'd7, 32'hFFFF_FFFF, 32'd1, 16'h1234, 0, 1, 0, 0, 5'd3, 1, 0, 0, 0);
        vec("lui", ex(32'h1234_0000, 32'd1, 3, 1, 0, 0, 0, 0));

        // Overflow
        nxt(); set_in(3'd6, 32'h7FFF_FFFF, 32'd1, 16'h0, 0, 0, 0, 0, 5'd4, 1, 1, 0, 0);
        vec("add_ovf_pos", ex(32'h8000_0000, 32'd1, 4, 0, 0, 0, 0, 1));
        nxt(); EXE_AluCtr = 3'd0;
        vec("addu_no_ovf", ex(32'h8000_0000, 32'd1, 4, 1, 1, 0, 0, 0));
        nxt(); set_in(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0, 0, 0, 0, 0, 5'd4, 1, 1, 0, 0);
        vec("add_ovf_neg", ex(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4, 0, 0, 0, 0, 1));

        // Immediate extension
        nxt(); set_in(3'd0, 32'h0, 32'h0, 16'h8000, 1, 1, 0, 0, 5'd3, 1, 0, 0, 0);
        vec("sext_imm", ex(32'hFFFF_8000, 32'h0, 3, 1, 0, 0, 0, 0));
        nxt(); EXE_ExtOP = 1'b0;
        vec("zext_imm", ex(32'h0000_8000, 32'h0, 3, 1, 0, 0, 0, 0));

        // Forwarding
        nxt(); set_in(3'd0, 32'hA, 32'h0, 16'h0, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
        vec("fwd_setup_mem", ex(32'hA, 32'h0, 5, 1, 0, 0, 0, 0));
        nxt(); set_wb(1, 5'd5, 32'hB);
        set_in(3'd0, 32'h100, 32'h0, 16'h0, 0, 0, 5'd5, 0, 5'd6, 1, 0, 0, 0);
        vec("fwd_a_mem_over_wb", ex(32'hA, 32'h0, 6, 1, 0, 0, 0, 0));
        nxt(); set_in(3'd0, 32'hA, 32'h0, 16'h0, 0, 0, 0, 0, 5'd5, 1, 0, 1, 1);
        vec("fwd_setup_load", ex(32'hA, 32'h0, 5, 1, 0, 1, 1, 0));
        nxt(); set_in(3'd0, 32'h100, 32'h0, 16'h0, 0, 0, 5'd5, 0, 5'd6, 0, 0, 0, 0);
        vec("fwd_a_load_uses_wb", ex(32'hB, 32'h0, 6, 0, 0, 0, 0, 0));
        nxt(); set_in(3'd0, 32'hA, 32'h0, 16'h0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
        vec("fwd_setup_r0", ex(32'hA, 32'h0, 0, 1, 0, 0, 0, 0));
        nxt(); set_wb(1, 5'd0, 32'hB);
        set_in(3'd0, 32'h100, 32'h0, 16'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        vec("fwd_r0_none", ex(32'h100, 32'h0, 0, 0, 0, 0, 0, 0));
        nxt(); set_wb(0, 5'd0, 32'h0);
        set_in(3'd0, 32'hA, 32'h0, 16'h0, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
        vec("fwd_setup_store", ex(32'hA, 32'h0, 5, 1, 0, 0, 0, 0));
        nxt(); set_in(3'd0, 32'h20, 32'h999, 16'h4, 0, 1, 0, 5'd5, 5'd0, 0, 1, 0, 0);
        vec("fwd_b_store_mem", ex(32'h24, 32'hA, 0, 0, 1, 0, 0, 0));
        nxt(); set_wb(1, 5'd5, 32'hB);
        set_in(3'd0, 32'h1, 32'h999, 16'h0, 0, 0, 0, 5'd5, 5'd7, 1, 0, 0, 0);
        vec("fwd_b_wb", ex(32'hC, 32'hB, 7, 1, 0, 0, 0, 0));

        // Hold / flush
        nxt(); set_wb(0, 5'd0, 32'h0);
        set_in(3'd0, 32'h5, 32'h3, 16'h0, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
        vec("hold_setup", ex(32'h8, 32'h3, 7, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            nxt(); hold = 1'b1;
            set_in(3'(i + 1), 32'h1000 + 32'(i), 32'h77, 16'h0, 0, 0, 0, 0, 5'(i + 9), 0, 1, 1, 1);
            vec($sformatf("hold_%0d", i), ex(32'h8, 32'h3, 7, 1, 0, 0, 0, 0));
        end
        nxt(); flush = 1'b1;
        vec("flush_and_hold", ZEROS);
        nxt(); flush = 1'b0; hold = 1'b0;
        set_in(3'd0, 32'h5, 32'h3, 16'h0, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
        vec("reload", ex(32'h8, 32'h3, 7, 1, 0, 0, 0, 0));
        nxt(); flush = 1'b1;
        vec("flush_only", ZEROS);
        nxt(); flush = 1'b0;
        set_in(3'd0, 32'h0, 32'h0, 16'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        vec("bubble", ex(32'h0, 32'h0, 0, 0, 0, 0, 0, 0));

        // Mid-cycle async reset, then hold keeps the cleared state
        nxt(); set_in(3'd0, 32'h5, 32'h3, 16'h0, 0, 0, 0, 0, 5'd7, 1, 1, 0, 0);
        vec("pre_reset", ex(32'h8, 32'h3, 7, 1, 1, 0, 0, 0));
        nxt(); #1 rst_n = 1'b0;
        #1 chk("reset_async", got, ZEROS);
        rst_n = 1'b1; hold = 1'b1;
        vec("hold_after_reset", ZEROS);
        nxt(); hold = 1'b0;
        vec("after_hold_release", ex(32'h8, 32'h3, 7, 1, 1, 0, 0, 0));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage plus EX/MEM pipeline register for the five-stage MIPS pipeline. Consumes the ID/EX register outputs, resolves RAW hazards by forwarding from the MEM and WB stages, extends the immediate, runs the 32-bit ALU, and registers result, store data and control toward the MEM stage. It sits directly downstream of the ID/EX register and directly upstream of data memory.

## Interface
Parameters: none. All data paths are fixed at 32 bits, register indices at 5 bits.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the other pipeline registers
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  insert bubble into EX/MEM on the next edge
- hold  in  1  freeze EX/MEM contents on the next edge
- EXE_MemWr, EXE_MemtoReg, EXE_RegWr, EXE_ExtOP, EXE_AluSrc, EXE_MemRead  in  1 each  control from ID/EX
- EXE_Rw, EXE_Rs, EXE_Rt  in  5 each  destination and source register indices
- EXE_busA, EXE_busB  in  32 each  register-file read data (busB is full 32 bits)
- EXE_imm16  in  16  immediate field
- EXE_AluCtr  in  3  ALU operation
- WB_RegWr  in  1, WB_Rw  in  5, WB_busW  in  32  write-back stage result for forwarding
- MEM_MemWr, MEM_MemtoReg, MEM_RegWr, MEM_MemRead  out  1 each  registered control
- MEM_Rw  out  5  registered destination
- MEM_ALUout  out  32  registered ALU result / memory address
- MEM_busB  out  32  registered store data (post-forwarding)
- MEM_Zero  out  1  registered (ALU result == 0)
- MEM_Overflow  out  1  registered signed-overflow flag (AluCtr 110 only)

## Operation
- Forward A: if MEM_RegWr && !MEM_MemtoReg && MEM_Rw!=0 && MEM_Rw==EXE_Rs, fwdA=MEM_ALUout; else if WB_RegWr && WB_Rw!=0 && WB_Rw==EXE_Rs, fwdA=WB_busW; else fwdA=EXE_busA. Forward B is identical using EXE_Rt and EXE_busB. MEM beats WB.
- Loads in MEM are never forwarded from MEM; load-use stalls are the hazard unit's job.
- ext = EXE_ExtOP ? sign-extend(imm16) : zero-extend(imm16). opB = EXE_AluSrc ? ext : fwdB. opA = fwdA.
- AluCtr: 000 addu, 001 subu, 010 and, 011 or, 100 slt (signed, result 0/1), 101 sltu, 110 add (signed, overflow-checked), 111 lui (opB[15:0]<<16).
- All arithmetic is modulo 2^32. Overflow applies to 110 only: operands share a sign and the sum's sign differs.
- On overflow the result is still registered, but MEM_RegWr and MEM_MemWr are forced to 0 and MEM_Overflow=1.
- Store data: MEM_busB = fwdB, always, regardless of AluSrc.

## Timing
- Reset (rst_n=0, asynchronous): every output is 0 immediately and stays 0 until the first falling edge after release.
- Latency: one falling edge from EXE_* inputs to MEM_* outputs. The ALU path is combinational within the cycle.
- Priority per edge: flush > hold > load. Flush zeroes every output. Hold keeps every output unchanged. Otherwise all outputs load new values.
- flush and hold together: flush wins.
- Forwarding samples MEM_* values as they stand before the edge, i.e. the instruction one ahead.
- A bubble in ID/EX (all zero) yields addu 0+0. MEM_Zero=1 is legal; MEM_RegWr=0 and MEM_MemWr=0 must follow from the zeroed controls.
- Reset mid-hold clears state. Hold after reset keeps zeros.

## Test plan
- Reset: assert rst_n=0 mid-cycle with non-zero state -> all outputs 0 without waiting for a clock edge.
- ALU sweep: A=0xFFFFFFFF, B=1, AluCtr 000..101 -> ALUout 0, 0xFFFFFFFE, 1, 0xFFFFFFFF, 1, 0. lui with imm 0x1234, AluSrc=1 -> 0x12340000.
- Overflow: add 0x7FFFFFFF+1 with EXE_RegWr=1 -> ALUout 0x80000000, MEM_Overflow=1, MEM_RegWr=0. Same operands with addu -> Overflow=0, RegWr=1.
- Forwarding: MEM holds Rw=5, ALUout=0xA, and WB_Rw=5, busW=0xB; EXE_Rs=5 -> operand A=0xA. With MEM_MemtoReg=1 -> A=0xB. With Rw=0 in both -> A=EXE_busA.
- Immediate extension: imm16=0x8000, AluSrc=1, addu with A=0 -> ExtOP=1 gives 0xFFFF8000, ExtOP=0 gives 0x00008000.
- Hold/flush: hold=1 for 3 edges with changing inputs -> outputs stable. flush=1 together with hold=1 -> all outputs 0 after the edge.
